// File: rtl/rdc_offense_log.sv
// rdc_offense_log: edge-detects RDC offense bits, serialises them and logs
// {core, event, timestamp} records into a FIFO drained over valid/ready.
//
// Ports:
//   clk_i, rstn_i        clock, async active-low reset
//   enable_i             logging enable (shared with the RDC)
//   clear_i              sync flush of FIFO, overflow flag and pending bits
//   irq_vec_i            RDC vector, bit = core*CORE_EVENTS+event
//   rd_valid_o/ready_i   read handshake for the head entry
//   rd_core_o/event_o    head entry indices
//   rd_ts_o              head entry timestamp
//   count_o              entries held
//   overflow_o           sticky record-dropped flag
//   irq_o                level interrupt while entries are pending
module rdc_offense_log #(
    parameter int N_CORES     = 2,
    parameter int CORE_EVENTS = 4,
    parameter int TS_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 8,
    localparam int N_BITS  = N_CORES * CORE_EVENTS,
    localparam int CW      = (N_CORES > 1) ? $clog2(N_CORES) : 1,
    localparam int EW      = (CORE_EVENTS > 1) ? $clog2(CORE_EVENTS) : 1,
    localparam int CNTW    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic [N_BITS-1:0]   irq_vec_i,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [CW-1:0]       rd_core_o,
    output logic [EW-1:0]       rd_event_o,
    output logic [TS_WIDTH-1:0] rd_ts_o,
    output logic [CNTW-1:0]     count_o,
    output logic                overflow_o,
    output logic                irq_o
);

    localparam int IW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = CW + EW + TS_WIDTH;

    logic [TS_WIDTH-1:0] ts;
    logic [N_BITS-1:0]   prev;
    logic [N_BITS-1:0]   pending;
    logic [N_BITS-1:0]   rise;
    logic [N_BITS-1:0]   sel_hot;
    logic [IW-1:0]       sel_idx;
    logic                svc;

    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CNTW-1:0]     count;
    logic                overflow;
    logic                full;
    logic                push;
    logic                pop;
    logic                drop;
    logic [CW-1:0]       svc_core;
    logic [EW-1:0]       svc_evt;
    logic [ENTRY_W-1:0]  head;

    assign rise = enable_i ? (irq_vec_i & ~prev) : '0;

    // Lowest set pending bit wins; scan from the top so the last hit sticks.
    always_comb begin
        sel_idx = '0;
        for (int i = N_BITS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    assign svc      = enable_i && (pending != '0);
    assign sel_hot  = svc ? (N_BITS'(1) << sel_idx) : '0;
    assign svc_core = CW'(32'(sel_idx) / CORE_EVENTS);
    assign svc_evt  = EW'(32'(sel_idx) % CORE_EVENTS);

    assign full = (count == CNTW'(FIFO_DEPTH));
    assign pop  = rd_valid_o && rd_ready_i;
    // A simultaneous pop frees the slot the push needs.
    assign push = svc && (!full || pop);
    assign drop = svc && full && !pop;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ts      <= '0;
            prev    <= '0;
            pending <= '0;
        end else begin
            ts   <= enable_i ? ts + 1'b1 : '0;
            prev <= enable_i ? irq_vec_i : '0;
            if (!enable_i || clear_i) begin
                pending <= '0;
            end else begin
                pending <= (pending | rise) & ~sel_hot;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {svc_core, svc_evt, ts};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign rd_valid_o = (count != '0);
    assign rd_core_o  = rd_valid_o ? head[ENTRY_W-1 -: CW] : '0;
    assign rd_event_o = rd_valid_o ? head[TS_WIDTH+EW-1 -: EW] : '0;
    assign rd_ts_o    = rd_valid_o ? head[TS_WIDTH-1:0] : '0;
    assign count_o    = count;
    assign overflow_o = overflow;
    assign irq_o      = rd_valid_o;

endmodule
